decrypt_word_packer: RTL and testbench
======================================

// Module: decrypt_word_packer
// PURPOSE
//  Sits directly downstream of the decryption unit and consumes its byte stream (dout/v).
//  Packs plaintext bytes little-endian into 32-bit words, buffers them in a DEPTH-entry FIFO,
//  and presents them on a valid/ready interface to the system bus.
//  The decrypt stage has no backpressure, so words are never stalled: overflow drops the word and sets a sticky flag.
// PARAMETERS
//  DEPTH  4  FIFO depth in 32-bit words; power of 2, >=2
//  AW     $clog2(DEPTH)  derived pointer width; not overridden by users
// PORTS
//  clk        input   1      clock, rising edge
//  rst        input   1      reset, asynchronous, active-low
//  din        input   8      decrypted byte (connects to decrypt dout)
//  din_v      input   1      byte valid (connects to decrypt v); no ready returned
//  flush      input   1      single-cycle pulse; push any partial word
//  out_ready  input   1      downstream accepts head word
//  clr_ovf    input   1      clears sticky overflow
//  out_data   output  32     head word; byte0 = [7:0]
//  out_bmask  output  4      valid-byte mask of head word (4'b1111 or partial 4'b0001/0011/0111)
//  out_valid  output  1      FIFO not empty
//  level      output  AW+1   words held, 0..DEPTH
//  overflow   output  1      sticky: a word was dropped
// BEHAVIOUR
//  Reset (rst=0, async): byte_cnt=0; assembly reg=0; wr/rd ptr=0.
//   Outputs: out_data=0, out_bmask=0, out_valid=0, level=0, overflow=0.
//  Assembler:
//   - On din_v=1, din is written to byte lane byte_cnt; byte_cnt increments mod 4.
//   - The byte that makes byte_cnt wrap 3->0 raises push with mask 4'b1111.
//   - The pushed word includes that same-cycle byte, built combinationally.
//  Flush:
//   - flush=1 with a partial word (byte_cnt>0, counting any same-cycle din_v byte) pushes it.
//   - Mask = (1<<n)-1; unused lanes are 0; byte_cnt returns to 0.
//   - flush with no bytes pending is a no-op.
//   - flush on the cycle the 4th byte arrives pushes one full word only.
//  Push acceptance:
//   - Accepted when level<DEPTH, or when level==DEPTH and a pop happens in the same cycle.
//   - Otherwise the word is dropped and overflow<=1. byte_cnt is still cleared and the assembler continues.
//  Pop: out_valid && out_ready at a rising edge; rd ptr increments mod DEPTH.
//  Level: next = level + push_ok - pop; simultaneous push/pop leaves level unchanged.
//  Latency: a word pushed at edge N shows on out_data/out_valid after edge N (1 cycle from last byte).
//  Head outputs: out_data/out_bmask are read from registered storage at rd ptr.
//   - When empty they show 0; gated, never stale contents.
//  out_valid holds until popped; out_data is stable while out_valid && !out_ready.
//  Overflow: clr_ovf clears it; if clr_ovf and a new drop occur in the same cycle, overflow stays 1.
//  Pointer wrap: AW-bit pointers wrap DEPTH-1 -> 0; full/empty come from level, not from pointer compare.
//  Reset mid-operation: partial word and all FIFO contents are discarded, with no output glitch beyond the async clear.
// TESTING
//  T1 bytes 11,22,33,44 with din_v on 4 consecutive cycles -> next cycle out_data=32'h44332211, out_bmask=4'hF, level=1.
//  T2 bytes AA,BB, then flush -> out_data=32'h0000BBAA, out_bmask=4'h3; a second flush with nothing pending -> no push.
//  T3 out_ready=0, push 5 full words at DEPTH=4 -> level=4, overflow=1, head=first word.
//     Then clr_ovf -> overflow=0.
//  T4 level=4, out_ready=1 on the cycle a 4th byte arrives -> push accepted, level stays 4, overflow stays 0.
//  T5 stream 40 bytes with out_ready toggling 1/0 -> 10 words in order across pointer wrap, no drop.
//  T6 rst low mid-word (byte_cnt=2, level=3) -> all outputs 0 immediately.
//     Next 4 bytes form a fresh word with byte0 at [7:0].

Source files
------------

// File: rtl/decrypt_word_packer.sv
// Packs the decrypt byte stream little-endian into 32-bit words and queues them in a DEPTH-word FIFO.
// A word is visible one cycle after its last byte (or flush); no backpressure upstream, so a push into a full FIFO is dropped and flagged.
module decrypt_word_packer #(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    din,
    input  logic          din_v,
    input  logic          flush,
    input  logic          out_ready,
    input  logic          clr_ovf,
    output logic [31:0]   out_data,
    output logic [3:0]    out_bmask,
    output logic          out_valid,
    output logic [AW:0]   level,
    output logic          overflow
);

    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [1:0]    byte_cnt;
    logic [23:0]   asm_reg;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [31:0]   mem_data [DEPTH];
    logic [3:0]    mem_mask [DEPTH];

    logic [31:0] cur_word;
    logic [2:0]  n_bytes;
    logic [3:0]  push_mask;
    logic        push;
    logic        push_ok;
    logic        pop;
    logic        drop;

    // Lanes at or above byte_cnt are always zero in asm_reg, so a partial word needs no extra masking.
    always_comb begin
        cur_word = {8'h00, asm_reg};
        for (int i = 0; i < 4; i++) begin
            if (din_v && byte_cnt == 2'(i))
                cur_word[i*8 +: 8] = din;
        end
    end

    assign n_bytes = {1'b0, byte_cnt} + {2'b00, din_v};
    assign push    = (n_bytes == 3'd4) || (flush && n_bytes != 3'd0);

    always_comb begin
        case (n_bytes)
            3'd1:    push_mask = 4'b0001;
            3'd2:    push_mask = 4'b0011;
            3'd3:    push_mask = 4'b0111;
            3'd4:    push_mask = 4'b1111;
            default: push_mask = 4'b0000;
        endcase
    end

    assign out_valid = (level != '0);
    assign pop       = out_valid && out_ready;
    assign push_ok   = push && ((level != FULL_LVL) || pop);
    assign drop      = push && !push_ok;

    assign out_data  = out_valid ? mem_data[rd_ptr] : 32'h0;
    assign out_bmask = out_valid ? mem_mask[rd_ptr] : 4'h0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_cnt <= 2'd0;
            asm_reg  <= 24'h0;
        end else if (push) begin
            byte_cnt <= 2'd0;
            asm_reg  <= 24'h0;
        end else if (din_v) begin
            byte_cnt <= byte_cnt + 2'd1;
            asm_reg  <= cur_word[23:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            // A drop in the same cycle as a clear wins so no loss goes unreported.
            if (drop)
                overflow <= 1'b1;
            else if (clr_ovf)
                overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_data[wr_ptr] <= cur_word;
            mem_mask[wr_ptr] <= push_mask;
        end
    end

endmodule

// File: tb/tb_decrypt_word_packer.sv
// Directed bench for decrypt_word_packer at DEPTH=4: assembly, flush, overflow, full push/pop, wrap, async reset.
module tb_decrypt_word_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  din;
    logic        din_v;
    logic        flush;
    logic        out_ready;
    logic        clr_ovf;
    logic [31:0] out_data;
    logic [3:0]  out_bmask;
    logic        out_valid;
    logic [2:0]  level;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    decrypt_word_packer #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_v     (din_v),
        .flush     (flush),
        .out_ready (out_ready),
        .clr_ovf   (clr_ovf),
        .out_data  (out_data),
        .out_bmask (out_bmask),
        .out_valid (out_valid),
        .level     (level),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [7:0] b);
        din   = b;
        din_v = 1'b1;
        tick();
        din_v = 1'b0;
    endtask

    // Word k of the overflow scenario carries bytes 8'h10*k + 0..3.
    function automatic logic [31:0] ovf_word(input int k);
        logic [7:0] b;
        b = 8'(16 * k);
        return {b + 8'd3, b + 8'd2, b + 8'd1, b};
    endfunction

    task automatic test_reset();
        #2;
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 0", out_data); end
        checks++; if (out_bmask !== 4'h0) begin errors++; $display("FAIL reset_bmask got %h exp 0", out_bmask); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", overflow); end
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_full_word();
        put(8'h11); put(8'h22); put(8'h33);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL t1_early_valid got %b exp 0", out_valid); end
        put(8'h44);
        checks++; if (out_data !== 32'h44332211) begin errors++; $display("FAIL t1_data got %h exp 44332211", out_data); end
        checks++; if (out_bmask !== 4'hF) begin errors++; $display("FAIL t1_bmask got %h exp f", out_bmask); end
        checks++; if (level !== 3'd1) begin errors++; $display("FAIL t1_level got %0d exp 1", level); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL t1_pop_level got %0d exp 0", level); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL t1_empty_data got %h exp 0", out_data); end
    endtask

    task automatic test_flush();
        put(8'hAA); put(8'hBB);
        flush = 1'b1; tick(); flush = 1'b0;
        checks++; if (out_data !== 32'h0000BBAA) begin errors++; $display("FAIL t2_data got %h exp 0000bbaa", out_data); end
        checks++; if (out_bmask !== 4'h3) begin errors++; $display("FAIL t2_bmask got %h exp 3", out_bmask); end
        flush = 1'b1; tick(); flush = 1'b0;
        checks++; if (level !== 3'd1) begin errors++; $display("FAIL t2_noop_flush got %0d exp 1", level); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        // Flush together with a single byte: that byte alone forms the word.
        din = 8'hCC; din_v = 1'b1; flush = 1'b1; tick(); din_v = 1'b0; flush = 1'b0;
        checks++; if (out_data !== 32'h000000CC) begin errors++; $display("FAIL t2_samecyc_data got %h exp 000000cc", out_data); end
        checks++; if (out_bmask !== 4'h1) begin errors++; $display("FAIL t2_samecyc_bmask got %h exp 1", out_bmask); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        // Flush on the 4th byte yields one full word only.
        put(8'h01); put(8'h02); put(8'h03);
        din = 8'h04; din_v = 1'b1; flush = 1'b1; tick(); din_v = 1'b0; flush = 1'b0;
        tick();
        checks++; if (level !== 3'd1) begin errors++; $display("FAIL t2_flush4_level got %0d exp 1", level); end
        checks++; if (out_data !== 32'h04030201 || out_bmask !== 4'hF) begin
            errors++; $display("FAIL t2_flush4_word got %h/%h exp 04030201/f", out_data, out_bmask); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL t2_drain got %0d exp 0", level); end
    endtask

    task automatic test_overflow();
        logic [31:0] w;
        for (int k = 0; k < 5; k++) begin
            w = ovf_word(k);
            for (int j = 0; j < 4; j++) put(w[j*8 +: 8]);
        end
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL t3_level got %0d exp 4", level); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL t3_ovf got %b exp 1", overflow); end
        checks++; if (out_data !== ovf_word(0)) begin errors++; $display("FAIL t3_head got %h exp %h", out_data, ovf_word(0)); end
        clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL t3_clr got %b exp 0", overflow); end
        // A drop on the same cycle as clr_ovf keeps the flag set.
        put(8'h50); put(8'h51); put(8'h52);
        din = 8'h53; din_v = 1'b1; clr_ovf = 1'b1; tick(); din_v = 1'b0; clr_ovf = 1'b0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL t3_clr_vs_drop got %b exp 1", overflow); end
        clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL t3_clr2 got %b exp 0", overflow); end
    endtask

    task automatic test_push_pop_full();
        logic [31:0] exp_q [$];
        put(8'h61); put(8'h62); put(8'h63);
        din = 8'h64; din_v = 1'b1; out_ready = 1'b1; tick(); din_v = 1'b0; out_ready = 1'b0;
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL t4_level got %0d exp 4", level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL t4_ovf got %b exp 0", overflow); end
        exp_q = '{ovf_word(1), ovf_word(2), ovf_word(3), 32'h64636261};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_data !== exp_q[i]) begin errors++; $display("FAIL t4_drain%0d got %h exp %h", i, out_data, exp_q[i]); end
            tick();
        end
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL t4_empty got %b exp 0", out_valid); end
    endtask

    task automatic test_stream();
        int popped = 0;
        logic [7:0]  b;
        logic [31:0] e;
        for (int i = 0; i < 50; i++) begin
            if (i < 40) begin
                din = 8'(8'h40 + i); din_v = 1'b1; out_ready = i[0];
            end else begin
                din_v = 1'b0; out_ready = 1'b1;
            end
            if (out_valid && out_ready) begin
                b = 8'(8'h40 + 4 * popped);
                e = {b + 8'd3, b + 8'd2, b + 8'd1, b};
                checks++; if (out_data !== e) begin errors++; $display("FAIL t5_word%0d got %h exp %h", popped, out_data, e); end
                popped++;
            end
            tick();
        end
        din_v = 1'b0; out_ready = 1'b0;
        checks++; if (popped != 10) begin errors++; $display("FAIL t5_count got %0d exp 10", popped); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL t5_ovf got %b exp 0", overflow); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL t5_level got %0d exp 0", level); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 14; i++) put(8'(8'h80 + i));
        checks++; if (level !== 3'd3) begin errors++; $display("FAIL t6_pre_level got %0d exp 3", level); end
        #2 rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || level !== 3'd0) begin
            errors++; $display("FAIL t6_async got valid %b level %0d exp 0/0", out_valid, level); end
        checks++; if (out_data !== 32'h0 || out_bmask !== 4'h0 || overflow !== 1'b0) begin
            errors++; $display("FAIL t6_async_out got %h/%h/%b exp 0", out_data, out_bmask, overflow); end
        @(negedge clk);
        rst = 1'b1;
        put(8'h05); put(8'h06); put(8'h07); put(8'h08);
        checks++; if (out_data !== 32'h08070605) begin errors++; $display("FAIL t6_fresh got %h exp 08070605", out_data); end
        checks++; if (level !== 3'd1) begin errors++; $display("FAIL t6_level got %0d exp 1", level); end
    endtask

    initial begin
        rst = 1'b0; din = 8'h0; din_v = 1'b0; flush = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
        test_reset();
        test_full_word();
        test_flush();
        test_overflow();
        test_push_pop_full();
        test_stream();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
